// File: rtl/memory_1024x16_pkg.sv
// Shared constants for the RISC240 memory system: strobe encodings and array geometry.
package memory_1024x16_pkg;

  typedef enum logic {
    MEM_WR    = 1'b0,
    MEM_NO_WR = 1'b1
  } wr_enable_t;

  typedef enum logic {
    MEM_RD    = 1'b0,
    MEM_NO_RD = 1'b1
  } rd_enable_t;

  localparam int unsigned MemDepth = 1024;
  localparam int unsigned MemWidth = 16;
  localparam int unsigned MemAddrW = 10;

endpackage

// File: rtl/memory_1024x16_bram.sv
// Plain 1024x16 storage array: synchronous write, combinational gated read.
module memory_1024x16_bram
  import memory_1024x16_pkg::*;
(
  input  logic                clock,
  input  logic                rden,
  input  logic                wren,
  input  logic [MemWidth-1:0] data,
  input  logic [MemAddrW-1:0] address,
  output logic [MemWidth-1:0] q
);

  logic [MemWidth-1:0] mem [MemDepth];

  always_ff @(posedge clock) begin
    if (wren) begin
      mem[address] <= data;
    end
  end

  assign q = rden ? mem[address] : '0;

endmodule

// File: rtl/memory_1024x16.sv
// RISC240 data memory wrapper around the shared 1024x16 array.
// Optional MEM_CLEAR_ON_RESET_EN: per-word written-valid vector, cleared by reset_L.
module memory_1024x16
  import memory_1024x16_pkg::*;
(
  input  logic                clock,
  input  logic                reset_L,
  input  logic                enable,
  input  wr_enable_t          we_L,
  input  logic [MemWidth-1:0] data_in,
  input  logic [MemAddrW-1:0] address,
  output logic [MemWidth-1:0] data_out
);

  logic                wren;
  logic                rden;
  logic [MemWidth-1:0] q;

  // Case equality keeps an X/Z strobe from writing; writes are dropped while in reset.
  assign wren = enable & (we_L === MEM_WR) & reset_L;
  assign rden = enable;

  memory_1024x16_bram bram (
    .clock   (clock),
    .rden    (rden),
    .wren    (wren),
    .data    (data_in),
    .address (address),
    .q       (q)
  );

`ifdef MEM_CLEAR_ON_RESET_EN
  logic [MemDepth-1:0] valid_q;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      valid_q <= '0;
    end else if (wren) begin
      valid_q[address] <= 1'b1;
    end
  end

  assign data_out = valid_q[address] ? q : '0;
`else
  assign data_out = q;
`endif

endmodule

// File: tb/tb_memory_1024x16.sv
// Scoreboard bench for memory_1024x16; expectations follow MEM_CLEAR_ON_RESET_EN if defined.
module tb_memory_1024x16;
  import memory_1024x16_pkg::*;

  logic        clock = 1'b0;
  logic        reset_L;
  logic        enable;
  wr_enable_t  we_L;
  logic [15:0] data_in;
  logic [9:0]  address;
  logic [15:0] data_out;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } sb_item_t;

  sb_item_t sb_q[$];
  sb_item_t sb_item;
  int       checks   = 0;
  int       failures = 0;

`ifdef MEM_CLEAR_ON_RESET_EN
  localparam bit ClearEn = 1'b1;
`else
  localparam bit ClearEn = 1'b0;
`endif

  memory_1024x16 dut (
    .clock    (clock),
    .reset_L  (reset_L),
    .enable   (enable),
    .we_L     (we_L),
    .data_in  (data_in),
    .address  (address),
    .data_out (data_out)
  );

  always #5 clock = ~clock;

  // Monitor: compares data_out at the falling edge against the oldest pending expectation.
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      sb_item = sb_q.pop_front();
      checks++;
      if (data_out !== sb_item.exp) begin
        failures++;
        $display("FAIL %s: data_out=%h expected=%h", sb_item.name, data_out, sb_item.exp);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input logic [15:0] e, input string n);
    sb_q.push_back('{exp: e, name: n});
  endtask

  task automatic drive(input logic en, input wr_enable_t we, input logic [15:0] d,
                       input logic [9:0] a);
    enable  = en;
    we_L    = we;
    data_in = d;
    address = a;
  endtask

  task automatic wr(input logic [9:0] a, input logic [15:0] d);
    drive(1'b1, MEM_WR, d, a);
    step();
  endtask

  task automatic rd(input logic [9:0] a, input logic [15:0] e, input string n);
    drive(1'b1, MEM_NO_WR, 16'h0000, a);
    expect_out(e, n);
    step();
  endtask

  logic [15:0] x_exp;

  initial begin
    reset_L = 1'b0;
    drive(1'b0, MEM_NO_WR, 16'h0000, 10'h000);
    step();
    expect_out(16'h0000, "reset_disabled");
    step();
    reset_L = 1'b1;

    if (ClearEn) rd(10'h005, 16'h0000, "reset_read_unwritten");

    wr(10'h005, 16'hBEEF);
    rd(10'h005, 16'hBEEF, "basic_readback");
    if (ClearEn) rd(10'h006, 16'h0000, "unwritten_neighbour");

    // Deselected write must neither store nor drive the output.
    drive(1'b0, MEM_WR, 16'h1234, 10'h005);
    expect_out(16'h0000, "enable_low_output");
    step();
    rd(10'h005, 16'hBEEF, "enable_low_no_write");

    wr(10'h000, 16'hAAAA);
    wr(10'h3FF, 16'h5555);
    rd(10'h000, 16'hAAAA, "boundary_low");
    rd(10'h3FF, 16'h5555, "boundary_high");
    rd(10'h005, 16'hBEEF, "boundary_no_alias");

    wr(10'h010, 16'h0001);
    drive(1'b1, MEM_WR, 16'h0002, 10'h010);
    expect_out(16'h0001, "same_cycle_old");
    step();
    rd(10'h010, 16'h0002, "same_cycle_new");

    // An X strobe must not write; if the simulator resolves X to a value, model that value.
    drive(1'b1, wr_enable_t'(1'bx), 16'hFFFF, 10'h010);
    x_exp = (we_L === MEM_WR) ? 16'hFFFF : 16'h0002;
    step();
    rd(10'h010, x_exp, "x_strobe_no_write");

    // Reset asserted mid-cycle with a write pending: the write is discarded.
    drive(1'b1, MEM_WR, 16'h7777, 10'h010);
    #1;
    reset_L = 1'b0;
    expect_out(ClearEn ? 16'h0000 : x_exp, "in_reset_read");
    step();
    reset_L = 1'b1;
    rd(10'h010, ClearEn ? 16'h0000 : x_exp,   "post_reset_0x010");
    rd(10'h005, ClearEn ? 16'h0000 : 16'hBEEF, "post_reset_0x005");
    rd(10'h000, ClearEn ? 16'h0000 : 16'hAAAA, "post_reset_0x000");
    rd(10'h3FF, ClearEn ? 16'h0000 : 16'h5555, "post_reset_0x3ff");

    drive(1'b0, MEM_NO_WR, 16'h0000, 10'h000);
    for (int i = 0; i < 10; i++) begin
      if (sb_q.size() == 0) break;
      step();
    end
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
